// File: rtl/rng_pkg.sv
// Shared rng definitions: mode encodings and default sizing constants.
package rng_pkg;

    typedef enum logic [1:0] {
        MODE_UNIFORM = 2'd0,
        MODE_TRI     = 2'd1,
        MODE_RAW     = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    localparam int BX_DEF    = 8;
    localparam int BY_DEF    = 8;
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/rng_fifo.sv
// Output FIFO for rng_stream; the head word and empty/full flags are registered.
module rng_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rd_nxt  = rd_ptr + AW'(do_pop);
        cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // NOTE: storage is deliberately not reset; dout and the flags are, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            cnt    <= cnt_nxt;
            empty  <= (cnt_nxt == '0);
            full   <= (cnt_nxt == (AW+1)'(DEPTH));
            // The new head is the word being written when it lands exactly at the read pointer.
            if (cnt_nxt != '0)
                dout <= (do_push && (rd_nxt == wr_ptr)) ? din : mem[rd_nxt];
        end
    end

endmodule

// File: rtl/rng_stream.sv
// Serial entropy collector producing uniform, triangular or raw words through an output FIFO.
// Build option: define RNG_DROP_CNT_EN to add the saturating 16-bit drop_cnt output.
module rng_stream
    import rng_pkg::*;
#(
    parameter int BX    = BX_DEF,
    parameter int BY    = BY_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bits_in,
    input  logic          bits_in_valid,
    input  logic [1:0]    mode,
    output logic [BY-1:0] rng,
    output logic          valid,
    input  logic          ready,
    output logic          overflow
`ifdef RNG_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);
    localparam int CW = $clog2(BX);

    logic [CW-1:0]    bit_cnt;
    logic [BX-1:0]    samp, u0, u_full;
    logic [BX:0]      sum;
    logic [BX+BY-1:0] uni_w, raw_w;
    logic [BX+BY:0]   tri_w;
    logic [BY-1:0]    res, res_uni, res_tri, res_raw;
    logic             pend, last_bit, res_v, full, empty, pop, drop;
    mode_e            cur_mode, mode_in;

    always_comb begin
        u_full       = samp;
        u_full[BX-1] = bits_in;
        sum          = {1'b0, u0} + {1'b0, u_full};
        // Appending BY zeros lets one slice cover both truncation and zero padding.
        uni_w        = {u_full, {BY{1'b0}}};
        tri_w        = {sum, {BY{1'b0}}};
        raw_w        = {{BY{1'b0}}, u_full};
        res_uni      = uni_w[BX+BY-1 -: BY];
        res_tri      = tri_w[BX+BY -: BY];
        res_raw      = raw_w[BY-1:0];
        mode_in      = (mode == MODE_TRI) ? MODE_TRI :
                       (mode == MODE_RAW) ? MODE_RAW : MODE_UNIFORM;
        last_bit     = bits_in_valid && (bit_cnt == CW'(BX - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            samp     <= '0;
            u0       <= '0;
            pend     <= 1'b0;
            cur_mode <= MODE_UNIFORM;
            res      <= '0;
            res_v    <= 1'b0;
        end else begin
            res_v <= 1'b0;
            if (bits_in_valid) begin
                samp[bit_cnt] <= bits_in;
                bit_cnt       <= last_bit ? '0 : bit_cnt + CW'(1);
                if (bit_cnt == '0) begin
                    cur_mode <= mode_in;
                    if (mode_in != cur_mode) pend <= 1'b0;
                end
                if (last_bit) begin
                    case (cur_mode)
                        MODE_TRI: begin
                            if (pend) begin
                                res   <= res_tri;
                                res_v <= 1'b1;
                                pend  <= 1'b0;
                            end else begin
                                u0   <= u_full;
                                pend <= 1'b1;
                            end
                        end
                        MODE_RAW: begin
                            res   <= res_raw;
                            res_v <= 1'b1;
                        end
                        default: begin
                            res   <= res_uni;
                            res_v <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign valid = !empty;
    assign pop   = valid && ready;
    assign drop  = res_v && full && !pop;

    rng_fifo #(
        .W     (BY),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_v),
        .din   (res),
        .pop   (pop),
        .dout  (rng),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef RNG_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt <= '0;
        else if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule
